uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- Serial receiver stage directly upstream of the PC-to-Atlys header/packet parser.
- Converts the asynchronous UART line from the PC (8N1, LSB first) into parallel bytes.
- Presents each byte with a one-cycle `received` strobe, which the parser consumes as rx_byte/received.
- Uses 16x oversampling, 3-sample majority vote, false-start rejection and framing-error detection.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIV, CLK_FREQ/(BAUD*16), clocks per oversample tick, integer-truncated. Must be >= 2. Default evaluates to 54.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- rx_i  input  1  serial line from the PC; asynchronous; idles high.
- rx_byte  output  8  last correctly framed byte.
- received  output  1  one-cycle strobe; rx_byte is valid and new in this cycle.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (rst_n_i=0, asynchronous): all of the following take effect immediately.
  - rx_byte=0x00, received=0, frame_err=0, busy=0.
  - State=IDLE, all counters cleared.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame: no strobe, no partial byte.
- Synchronizer: rx_i passes through 2 flops (rx_s). All decisions use rx_s only.
- Tick generator:
  - Counter 0..DIV-1 runs freely only while busy.
  - tick=1 for one clock when the counter equals DIV-1.
  - Counter is cleared when entering START.
- Sample counter: 4 bits, counts ticks 0..15 within a bit and wraps 15->0.
- Majority vote:
  - rx_s is captured on ticks 7, 8 and 9.
  - Bit value = majority of the 3 samples, decided at tick 9.
- State machine:
  - IDLE: on rx_s=0 -> START; busy=1.
  - START: at tick 9, vote=1 -> IDLE (false start, no strobe). Vote=0 -> DATA, bit counter=0.
  - DATA: at each tick 9, shift the voted bit into shift[7] (shift right, so LSB arrives first); bit counter +1. After bit 7 -> STOP.
  - STOP, vote=1: rx_byte<=shift; received=1 on the next clock; then -> IDLE.
  - STOP, vote=0: frame_err=1 on the next clock; rx_byte unchanged; then -> WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s=1, then -> IDLE. Prevents a break condition from retriggering starts.
- busy=0 only in IDLE.
- Latency:
  - received rises 1 clock after the stop-bit tick-9 vote.
  - This is about 9.6 bit times after the falling edge of the start bit, plus 2 synchronizer clocks.
- Back-to-back frames:
  - IDLE is re-entered mid-stop-bit, so a start edge arriving immediately after the stop bit is caught.
  - No minimum gap beyond one stop bit is required.
- received and frame_err are never high in the same cycle.
- Each strobe lasts exactly one clock.
- No receive buffer: a byte is overwritten by the next frame. The consumer must sample rx_byte on the received cycle.

Test Plan:
- All scenarios use CLK_FREQ=1600000, BAUD=10000 (DIV=10, 160 clocks/bit).
1. Single 0x80: drive one 8N1 frame -> one received pulse, rx_byte=0x80, frame_err=0, busy falls within 8 clocks after the pulse.
2. Back-to-back 0x80, 0x12, 0x34 with exactly one stop bit each -> three received pulses at ~1600-clock spacing carrying 0x80, 0x12, 0x34 in order; this is the header-parser packet sequence.
3. Glitch: rx_i low for 30 clocks then high -> busy pulses then clears after ~9 ticks; no received, no frame_err; a subsequent 0x5A is received correctly.
4. Framing error: frame 0x55 with stop bit low for 2 bit times, previous byte 0x80 -> frame_err pulse, no received, rx_byte stays 0x80. After the line stays high for 1 bit, 0xA5 is received correctly.
5. Reset mid-frame: assert rst_n_i for 3 clocks after 4 data bits of 0xFF -> outputs 0/0x00 immediately, no strobe. The next full frame 0x3C gives rx_byte=0x3C.
6. Majority vote: frame 0x00 with rx_i forced high for 10 clocks around the tick-8 sample of bit 3 -> rx_byte=0x00, received pulse, no frame_err.

Source files
------------

// File: rtl/uart_rx_byte_if.sv
// Byte-level view of the UART receiver: serial line in, framed byte and status strobes out.
// The receiver binds to the slave modport; whatever drives the line binds to master.
interface uart_rx_byte_if;
  logic       rx_i;
  logic [7:0] rx_byte;
  logic       received;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx_i,
    input  rx_byte,
    input  received,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx_i,
    output rx_byte,
    output received,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, false-start rejection,
// framing-error detection with a wait-for-idle guard against break conditions.
module uart_rx_byte #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
  input logic            clk_i,
  input logic            rst_n_i,
  uart_rx_byte_if.slave  bus
);

  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta, rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       smp_cnt;
  logic [2:0]       bit_cnt;
  logic             smp7, smp8;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_q;
  logic             received_q, frame_err_q;

  logic busy_int, tick, tick9, vote;
  logic enter_start, shift_en, load_byte, set_err;

  // Two-flop synchronizer, preset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking so both flops sample the pre-edge values and form a real two-stage chain.
      rx_meta <= bus.rx_i;
      rx_s    <= rx_meta;
    end
  end

  assign busy_int = (state_q != IDLE);
  assign tick     = busy_int && (div_cnt == DIV_LAST);
  assign tick9    = tick && (smp_cnt == 4'd9);
  assign vote     = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an assignment would infer a latch.
    state_d     = state_q;
    enter_start = 1'b0;
    shift_en    = 1'b0;
    load_byte   = 1'b0;
    set_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d     = START;
          enter_start = 1'b1;
        end
      end
      START: begin
        if (tick9) state_d = vote ? IDLE : DATA;
      end
      DATA: begin
        if (tick9) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving mid-stop-bit lets an immediately following start edge be caught.
        if (tick9) begin
          if (vote) begin
            load_byte = 1'b1;
            state_d   = IDLE;
          end else begin
            set_err = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt     <= '0;
      smp_cnt     <= '0;
      bit_cnt     <= '0;
      smp7        <= 1'b1;
      smp8        <= 1'b1;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      received_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      received_q  <= load_byte;
      frame_err_q <= set_err;

      if (enter_start) begin
        div_cnt <= '0;
        smp_cnt <= '0;
        bit_cnt <= '0;
      end else if (busy_int) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) smp_cnt <= smp_cnt + 4'd1;
        if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      end

      if (tick && smp_cnt == 4'd7) smp7 <= rx_s;
      if (tick && smp_cnt == 4'd8) smp8 <= rx_s;

      // LSB arrives first, so shift right and insert at the top.
      if (shift_en)  shift_q   <= {vote, shift_q[7:1]};
      if (load_byte) rx_byte_q <= shift_q;
    end
  end

  assign bus.rx_byte   = rx_byte_q;
  assign bus.received  = received_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_int;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at DIV=10 (160 clocks per bit): stimulus queues
// expected strobes, an independent monitor pops and compares on every received/frame_err.
module tb_uart_rx_byte;

  localparam int BIT_CLKS = 160;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_byte_if bus ();

  uart_rx_byte #(
    .CLK_FREQ (1600000),
    .BAUD     (10000)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef enum int {EV_RX, EV_FERR} ev_t;
  typedef struct {
    ev_t        kind;
    logic [7:0] data;
  } exp_t;

  exp_t    exp_q[$];
  longint  rx_stamp[$];
  longint  cyc = 0;
  int      n_vec = 0;
  int      n_err = 0;
  exp_t    mon_e;
  logic    prev_rcv = 1'b0;
  logic    prev_ferr = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_rx(input logic [7:0] b);
    exp_t e;
    e.kind = EV_RX;
    e.data = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_ferr(input logic [7:0] held);
    exp_t e;
    e.kind = EV_FERR;
    e.data = held;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.received) begin
      rx_stamp.push_back(cyc);
      check("received_width", {31'd0, prev_rcv}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_received: got byte 0x%0h, want no strobe", bus.rx_byte);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {30'd0, bus.frame_err, bus.received},
              (mon_e.kind == EV_RX) ? 32'd1 : 32'd2);
        check("rx_byte", {24'd0, bus.rx_byte}, {24'd0, mon_e.data});
      end
    end else if (bus.frame_err) begin
      check("frame_err_width", {31'd0, prev_ferr}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_frame_err: got frame_err=1 byte 0x%0h, want no strobe", bus.rx_byte);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {30'd0, bus.frame_err, bus.received},
              (mon_e.kind == EV_RX) ? 32'd1 : 32'd2);
        check("rx_byte_held", {24'd0, bus.rx_byte}, {24'd0, mon_e.data});
      end
    end
    prev_rcv  <= bus.received;
    prev_ferr <= bus.frame_err;
  end

  task automatic line(input logic v, input int n);
    bus.rx_i = v;
    repeat (n) @(negedge clk);
  endtask

  // glitch_bit >= 0 forces the line high for 10 clocks around the tick-8 sample of that bit.
  task automatic send_frame(input logic [7:0] b, input int glitch_bit = -1);
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        line(b[i], 85);
        line(1'b1, 10);
        line(b[i], BIT_CLKS - 95);
      end else begin
        line(b[i], BIT_CLKS);
      end
    end
    line(1'b1, BIT_CLKS);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_i = 1'b1;
    #1;
    check("reset_rx_byte",   {24'd0, bus.rx_byte}, 32'd0);
    check("reset_received",  {31'd0, bus.received}, 32'd0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("reset_busy",      {31'd0, bus.busy}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    line(1'b1, 50);

    // 1: single 0x80, busy must be down within 8 clocks of the strobe
    expect_rx(8'h80);
    fork
      send_frame(8'h80);
      begin
        int n = 0;
        while (!bus.received && n < 2000) begin
          @(negedge clk);
          n++;
        end
        check("t1_received_seen", {31'd0, bus.received}, 32'd1);
        check("t1_frame_err", {31'd0, bus.frame_err}, 32'd0);
        n = 0;
        while (bus.busy && n < 8) begin
          @(negedge clk);
          n++;
        end
        check("t1_busy_fall", {31'd0, bus.busy}, 32'd0);
      end
    join
    wait_drain("t1_drain");

    // 2: back-to-back header sequence, one stop bit each
    rx_stamp.delete();
    expect_rx(8'h80);
    expect_rx(8'h12);
    expect_rx(8'h34);
    send_frame(8'h80);
    send_frame(8'h12);
    send_frame(8'h34);
    wait_drain("t2_drain");
    check("t2_count", rx_stamp.size(), 32'd3);
    if (rx_stamp.size() == 3) begin
      for (int i = 1; i < 3; i++)
        check("t2_spacing", 32'(rx_stamp[i] - rx_stamp[i-1]), 32'd1600);
    end

    // 3: 30-clock glitch is a false start
    line(1'b0, 30);
    check("t3_busy_high", {31'd0, bus.busy}, 32'd1);
    line(1'b1, 170);
    check("t3_busy_clear", {31'd0, bus.busy}, 32'd0);
    expect_rx(8'h5A);
    send_frame(8'h5A);
    wait_drain("t3_drain");

    // 4: framing error keeps the previous byte
    expect_rx(8'h80);
    send_frame(8'h80);
    expect_ferr(8'h80);
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) line(i[0] ? 1'b0 : 1'b1, BIT_CLKS);
    line(1'b0, 2 * BIT_CLKS);
    line(1'b1, BIT_CLKS);
    check("t4_rx_byte_hold", {24'd0, bus.rx_byte}, 32'h80);
    expect_rx(8'hA5);
    send_frame(8'hA5);
    wait_drain("t4_drain");

    // 5: reset after four data bits of 0xFF
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) line(1'b1, BIT_CLKS);
    rst_n    = 1'b0;
    bus.rx_i = 1'b1;
    #1;
    check("t5_rst_rx_byte",   {24'd0, bus.rx_byte}, 32'd0);
    check("t5_rst_received",  {31'd0, bus.received}, 32'd0);
    check("t5_rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("t5_rst_busy",      {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    line(1'b1, BIT_CLKS);
    expect_rx(8'h3C);
    send_frame(8'h3C);
    wait_drain("t5_drain");
    check("t5_rx_byte", {24'd0, bus.rx_byte}, 32'h3C);

    // 6: single-sample glitch on bit 3 is outvoted
    expect_rx(8'h00);
    send_frame(8'h00, 3);
    wait_drain("t6_drain");

    line(1'b1, 100);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
